meta_state_array: RTL and testbench

META_STATE_ARRAY -- requirements
Module: meta_state_array

---
 rtl/meta_state_array.sv | 127 ++++++++++++
 tb/tb_meta_state_array.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/meta_state_array.sv
// Set/way metadata array holding two 2-bit state fields per entry. After reset the
// array is cleared one set per cycle, then serves one-cycle reads with write-first forwarding.
module meta_state_array #(
    parameter int SETS = 128,
    parameter int WAYS = 16
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    w_valid,
    input  logic [$clog2(SETS)-1:0] w_set,
    input  logic [$clog2(WAYS)-1:0] w_way,
    input  logic [1:0]              w_data_0_state,
    input  logic [1:0]              w_data_1_state,

    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [$clog2(SETS)-1:0] r_set,
    input  logic [$clog2(WAYS)-1:0] r_way,

    output logic                    resp_valid,
    output logic [1:0]              resp_data_0_state,
    output logic [1:0]              resp_data_1_state,

    output logic                    init_done,
    output logic                    w_drop
);

    localparam int SET_W = $clog2(SETS);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    typedef struct packed {
        logic [1:0] s1;
        logic [1:0] s0;
    } entry_t;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   init_cnt_q, init_cnt_d;
    logic               resp_valid_q, resp_valid_d;
    entry_t             resp_q, resp_d;
    entry_t             mem_q [SETS][WAYS];

    logic               in_ready;
    logic               rd_accept;
    logic               wr_en;
    logic               fwd_hit;
    entry_t             wr_entry;
    entry_t             rd_entry;

    assign in_ready  = (state_q == ST_READY);
    assign rd_accept = r_valid && in_ready;
    assign wr_en     = reset && w_valid && in_ready;
    assign wr_entry  = '{s1: w_data_1_state, s0: w_data_0_state};
    assign rd_entry  = mem_q[r_set][r_way];
    assign fwd_hit   = wr_en && (w_set == r_set) && (w_way == r_way);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == SET_W'(SETS - 1)) begin
                    state_d    = ST_READY;
                    init_cnt_d = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // A write to the entry being read in the same cycle wins over the stored value.
    always_comb begin
        resp_valid_d = rd_accept;
        resp_d       = resp_q;
        if (rd_accept) begin
            resp_d = fwd_hit ? wr_entry : rd_entry;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    // NOTE: the array itself has no reset; its contents become defined only through
    // the INIT sweep, which keeps the storage free of a wide reset fan-out.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state_q == ST_INIT) begin
                for (int w = 0; w < WAYS; w++) begin
                    mem_q[init_cnt_q][w] <= '0;
                end
            end else if (wr_en) begin
                mem_q[w_set][w_way] <= wr_entry;
            end
        end
    end

    assign r_ready           = in_ready;
    assign init_done         = in_ready;
    assign w_drop            = reset && w_valid && (state_q == ST_INIT);
    assign resp_valid        = resp_valid_q;
    assign resp_data_0_state = resp_q.s0;
    assign resp_data_1_state = resp_q.s1;

endmodule

// File: tb/tb_meta_state_array.sv
// Bench for meta_state_array: directed stimulus with literal expectations plus an
// array-level reference model compared against the outputs on every cycle.
module tb_meta_state_array;

    localparam int SETS = 128;
    localparam int WAYS = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       w_valid = 1'b0;
    logic [6:0] w_set = '0;
    logic [3:0] w_way = '0;
    logic [1:0] w_data_0_state = '0;
    logic [1:0] w_data_1_state = '0;
    logic       r_valid = 1'b0;
    logic       r_ready;
    logic [6:0] r_set = '0;
    logic [3:0] r_way = '0;
    logic       resp_valid;
    logic [1:0] resp_data_0_state;
    logic [1:0] resp_data_1_state;
    logic       init_done;
    logic       w_drop;

    int n_cmp = 0;
    int n_bad = 0;

    meta_state_array #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clock             (clock),
        .reset             (reset),
        .w_valid           (w_valid),
        .w_set             (w_set),
        .w_way             (w_way),
        .w_data_0_state    (w_data_0_state),
        .w_data_1_state    (w_data_1_state),
        .r_valid           (r_valid),
        .r_ready           (r_ready),
        .r_set             (r_set),
        .r_way             (r_way),
        .resp_valid        (resp_valid),
        .resp_data_0_state (resp_data_0_state),
        .resp_data_1_state (resp_data_1_state),
        .init_done         (init_done),
        .w_drop            (w_drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges seen since reset, contents, and the pending response.
    bit         m_valid = 0;
    int         m_n = 0;
    logic [1:0] m_d0 [SETS][WAYS];
    logic [1:0] m_d1 [SETS][WAYS];
    bit         m_rv = 0;
    logic [1:0] m_r0 = '0;
    logic [1:0] m_r1 = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_valid = 1;
            m_n     = 0;
            m_rv    = 0;
            m_r0    = '0;
            m_r1    = '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    m_d0[s][w] = '0;
                    m_d1[s][w] = '0;
                end
        end else if (m_valid) begin
            if (m_n >= SETS && r_valid) begin
                m_rv = 1;
                if (w_valid && w_set == r_set && w_way == r_way) begin
                    m_r0 = w_data_0_state;
                    m_r1 = w_data_1_state;
                end else begin
                    m_r0 = m_d0[r_set][r_way];
                    m_r1 = m_d1[r_set][r_way];
                end
            end else begin
                m_rv = 0;
            end
            if (m_n >= SETS && w_valid) begin
                m_d0[w_set][w_way] = w_data_0_state;
                m_d1[w_set][w_way] = w_data_1_state;
            end
            if (m_n < SETS) m_n++;
        end
    end

    always @(negedge clock) begin
        if (m_valid && reset) begin
            check("model r_ready",    int'(r_ready),    int'(m_n >= SETS));
            check("model init_done",  int'(init_done),  int'(m_n >= SETS));
            check("model w_drop",     int'(w_drop),     int'(w_valid && m_n < SETS));
            check("model resp_valid", int'(resp_valid), int'(m_rv));
            check("model resp_d0",    int'(resp_data_0_state), int'(m_r0));
            check("model resp_d1",    int'(resp_data_1_state), int'(m_r1));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_write(input logic [6:0] s, input logic [3:0] w,
                            input logic [1:0] d0, input logic [1:0] d1);
        w_valid = 1'b1; w_set = s; w_way = w; w_data_0_state = d0; w_data_1_state = d1;
        step();
        w_valid = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] s, input logic [3:0] w);
        r_valid = 1'b1; r_set = s; r_way = w;
        step();
        r_valid = 1'b0;
    endtask

    task automatic check_resp(input string name, input logic [1:0] d0, input logic [1:0] d1);
        check({name, " valid"}, int'(resp_valid), 1);
        check({name, " d0"}, int'(resp_data_0_state), int'(d0));
        check({name, " d1"}, int'(resp_data_1_state), int'(d1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state.
        idle(3);
        check("rst init_done",  int'(init_done), 0);
        check("rst r_ready",    int'(r_ready), 0);
        check("rst resp_valid", int'(resp_valid), 0);
        check("rst resp_d0",    int'(resp_data_0_state), 0);
        check("rst w_drop",     int'(w_drop), 0);
        reset = 1'b1;

        // Write presented at cycle 10 of INIT is dropped.
        idle(10);
        w_valid = 1'b1; w_set = 7'd5; w_way = 4'd3; w_data_0_state = 2'b11; w_data_1_state = 2'b11;
        #1;
        check("init w_drop", int'(w_drop), 1);
        check("init r_ready", int'(r_ready), 0);
        step();
        w_valid = 1'b0;

        // init_done rises after exactly 128 edges.
        idle(116);
        check("cyc127 init_done", int'(init_done), 0);
        check("cyc127 r_ready",   int'(r_ready), 0);
        step();
        check("cyc128 init_done", int'(init_done), 1);
        check("cyc128 r_ready",   int'(r_ready), 1);

        do_read(7'd5, 4'd3);
        check_resp("dropped entry", 2'b00, 2'b00);

        do_write(7'h12, 4'h7, 2'b10, 2'b01);
        do_read(7'h12, 4'h7);
        check_resp("rd 12/7", 2'b10, 2'b01);
        do_read(7'h12, 4'h6);
        check_resp("rd 12/6", 2'b00, 2'b00);
        step();
        check("hold valid", int'(resp_valid), 0);
        check("hold d0", int'(resp_data_0_state), 0);

        // Same-cycle write and read of one entry: write-first forwarding.
        w_valid = 1'b1; w_set = 7'h40; w_way = 4'hF; w_data_0_state = 2'b11; w_data_1_state = 2'b11;
        do_read(7'h40, 4'hF);
        w_valid = 1'b0;
        check_resp("fwd 40/F", 2'b11, 2'b11);

        // Same-cycle write and read of different entries.
        w_valid = 1'b1; w_set = 7'h20; w_way = 4'h1; w_data_0_state = 2'b01; w_data_1_state = 2'b10;
        do_read(7'h12, 4'h7);
        w_valid = 1'b0;
        check_resp("indep rd 12/7", 2'b10, 2'b01);
        do_read(7'h20, 4'h1);
        check_resp("indep rd 20/1", 2'b01, 2'b10);

        // Back-to-back reads of sets 0..3 return in order.
        for (int i = 0; i < 4; i++) do_write(7'(i), 4'd2, 2'(i), 2'(3 - i));
        r_valid = 1'b1; r_way = 4'd2; r_set = 7'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_resp($sformatf("b2b set%0d", i), 2'(i), 2'(3 - i));
            if (i < 3) r_set = 7'(i + 1);
            else r_valid = 1'b0;
        end
        step();
        check("b2b hold d1", int'(resp_data_1_state), 0);

        // Reset during READY with a read presented: no response, full re-init.
        reset = 1'b0; r_valid = 1'b1; r_set = 7'h12; r_way = 4'h7;
        step();
        check("rst2 resp_valid", int'(resp_valid), 0);
        check("rst2 init_done",  int'(init_done), 0);
        check("rst2 resp_d0",    int'(resp_data_0_state), 0);
        reset = 1'b1; r_valid = 1'b0;
        idle(127);
        check("rst2 cyc127 init_done", int'(init_done), 0);
        step();
        check("rst2 cyc128 init_done", int'(init_done), 1);
        do_read(7'h12, 4'h7);
        check_resp("rst2 rd 12/7", 2'b00, 2'b00);
        do_read(7'h40, 4'hF);
        check_resp("rst2 rd 40/F", 2'b00, 2'b00);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
